ex_muldiv: RTL and testbench
============================

# ex_muldiv

- Execute-stage RV32M multiply/divide unit.
- Sits directly downstream of the ID/EX pipeline register and consumes its operand outputs (rs1/rs2 data, rd index).
- Runs iterative 32-step multiply and divide, and stalls the front of the pipeline while busy.
- Returns a registered result and destination index to the EX-stage writeback mux.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 supported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- i_start  in  1  M-extension instruction valid in EX.
- i_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_rs1_data  in  32  operand A; forwarded value.
- i_rs2_data  in  32  operand B; forwarded value.
- i_rd_index  in  5  destination register.
- i_flush  in  1  branch-mispredict kill.
- i_hold  in  1  downstream not advancing (DM/WFI wait).
- o_stall  out  1  freeze IF/ID and ID/EX.
- o_done  out  1  result valid.
- o_result  out  32  result.
- o_rd_index  out  5  captured destination.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE + i_start, normal case:
  - Capture operand magnitudes, sign flags, op, and rd.
  - Clear the 6-bit iteration counter.
  - Go to BUSY.
- IDLE + i_start, fast case: go directly to DONE with the result registered. Fast cases:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- BUSY:
  - One radix-2 step per cycle: shift-add for multiply, restoring subtract for divide.
  - Counter increments each step; after step 32 go to DONE.
- DONE entry: result takes the final sign correction.
  - Product negated if sign(A) XOR sign(B).
  - Quotient sign follows sign(A) XOR sign(B); remainder sign follows the dividend.
  - MUL returns low 32 bits; MULH/MULHSU/MULHU return high 32 bits of the 64-bit product.
  - MULHSU treats rs1 as signed and rs2 as unsigned; the *U ops treat both as unsigned.
- DONE:
  - If i_hold, stay in DONE with o_done and o_result stable.
  - Otherwise go to IDLE.
  - i_start is ignored in DONE; this prevents re-triggering the instruction still sitting in EX.
- o_stall (combinational) = (IDLE & i_start & !fast case) | BUSY. It is low in DONE so the pipeline advances and consumes the result.
- i_flush has top priority: any state goes to IDLE at the next edge and o_done clears. In IDLE, i_start is not accepted in a flush cycle.
- All 64-bit intermediate arithmetic is unsigned magnitude; wrap-around is discarded beyond 64 bits.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - o_done 0, o_result 0x00000000, o_rd_index 0.
  - o_stall forced 0 while rst is high.
- Iterative ops: start sampled at edge k, then steps at edges k+1..k+32. o_done is high during the cycle after edge k+32, so the op occupies 33 cycles in total.
- Fast cases: o_done is high in the cycle after edge k.
- o_done is high for exactly one cycle unless i_hold extends it.
- o_result and o_rd_index change only on entry to DONE.
- Reset mid-operation: immediate return to IDLE; the partial result is discarded.
- Flush in the same cycle as the final step: flush wins and no o_done is produced.

## Configuration
- FAST_MUL_EN defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle 33x33 signed multiplier.
  - They take the IDLE→DONE fast path with 1-cycle latency and no stall.
  - Divides are unchanged.
- FAST_MUL_EN undefined: all multiplies use the 32-step iterative path, with the same latency as divide.

## Test plan
- DIV 100 / 7 → o_stall high for 33 cycles, o_done in the cycle after edge k+32, o_result 14, o_rd_index echoed.
- REM 0xFFFFFFEC (-20) / 3 → 0xFFFFFFFE (-2); REMU of the same operands → 0xFFFFFFEB? no: 4294967276 mod 3 = 2 → 0x00000002.
- DIVU 5 / 0 → 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. Both assert o_done the cycle after start with no stall.
- MULH 0x80000000 * 0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF * 0xFFFFFFFF → 0xFFFFFFFF; MUL 0x10000 * 0x10000 → 0x00000000. Run both with and without FAST_MUL_EN and check latency.
- Start DIV, assert i_flush at step 10 → IDLE next edge, no o_done; a new i_start is accepted 1 cycle later and completes correctly.
- Hold i_hold high for 3 cycles during DONE → o_done and o_result stable for 4 cycles, no retrigger; rst asserted during BUSY → all outputs return to reset values immediately.

Source files
------------

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - EX-stage RV32M iterative multiply/divide unit; FAST_MUL_EN selects single-cycle multiply
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [4:0]      i_rd_index,
    input  logic            i_flush,
    input  logic            i_hold,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd_index
);

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULH  = 3'd1;
    localparam logic [2:0] OP_MULHU = 3'd3;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_next;
    logic [5:0]  cnt;
    logic [2:0]  op_q;
    logic        a_neg_q, b_neg_q;
    logic [31:0] opnd;       // multiplicand for multiply, divisor for divide
    logic [63:0] acc;        // multiply: {partial high, multiplier}; divide: {remainder, dividend/quotient}
    logic [4:0]  rd_q;
    logic [31:0] res_q;
    logic [4:0]  rd_out;

    logic        a_signed, b_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        div_zero, div_ovf, fast_mul, is_fast;
    logic [31:0] fast_val, fast_mul_val;
`ifdef FAST_MUL_EN
    logic signed [63:0] fast_a, fast_b, fast_prod;
`endif

    // Operand decode: signedness per op, magnitudes, and the single-cycle special cases
    always_comb begin
        a_signed = i_op[2] ? !i_op[0] : (i_op != OP_MULHU);
        b_signed = i_op[2] ? !i_op[0] : (i_op == OP_MUL || i_op == OP_MULH);
        a_neg    = a_signed & i_rs1_data[31];
        b_neg    = b_signed & i_rs2_data[31];
        a_mag    = a_neg ? -i_rs1_data : i_rs1_data;
        b_mag    = b_neg ? -i_rs2_data : i_rs2_data;
        div_zero = i_op[2] && (i_rs2_data == 32'd0);
        div_ovf  = i_op[2] && !i_op[0] && (i_rs1_data == 32'h8000_0000) && (i_rs2_data == 32'hFFFF_FFFF);
`ifdef FAST_MUL_EN
        fast_a       = {{32{a_signed & i_rs1_data[31]}}, i_rs1_data};
        fast_b       = {{32{b_signed & i_rs2_data[31]}}, i_rs2_data};
        fast_prod    = fast_a * fast_b;
        fast_mul     = !i_op[2];
        fast_mul_val = (i_op == OP_MUL) ? fast_prod[31:0] : fast_prod[63:32];
`else
        fast_mul     = 1'b0;
        fast_mul_val = 32'd0;
`endif
        is_fast = div_zero || div_ovf || fast_mul;
        if (div_zero) begin
            fast_val = i_op[1] ? i_rs1_data : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            fast_val = i_op[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            fast_val = fast_mul_val;
        end
    end

    logic [32:0] mul_sum, div_shift, div_trial;
    logic [63:0] step, prod;
    logic [31:0] quot, rem, final_val;

    // One radix-2 step plus the sign-corrected result used on the last step
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        div_shift = acc[63:31];
        div_trial = div_shift - {1'b0, opnd};
        if (op_q[2]) begin
            step = div_trial[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                                 : {div_trial[31:0], acc[30:0], 1'b1};
        end else begin
            step = {mul_sum, acc[31:1]};
        end
        prod = (a_neg_q ^ b_neg_q) ? -step : step;
        quot = (a_neg_q ^ b_neg_q) ? -step[31:0] : step[31:0];
        rem  = a_neg_q ? -step[63:32] : step[63:32];
        if (op_q[2]) begin
            final_val = op_q[1] ? rem : quot;
        end else begin
            final_val = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs; flush overrides everything
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = is_fast ? DONE : BUSY;
            BUSY:    if (cnt == 6'd31) state_next = DONE;
            DONE:    if (!i_hold) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (i_flush) begin
            state_next = IDLE;
        end
        o_stall = !rst && (((state == IDLE) && i_start && !is_fast) || (state == BUSY));
        o_done  = (state == DONE);
    end

    // Datapath: capture on start, iterate while busy, register result only on DONE entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 6'd0;
            op_q    <= 3'd0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            opnd    <= 32'd0;
            acc     <= 64'd0;
            rd_q    <= 5'd0;
            res_q   <= 32'd0;
            rd_out  <= 5'd0;
        end else if (!i_flush) begin
            if ((state == IDLE) && i_start) begin
                op_q    <= i_op;
                a_neg_q <= a_neg;
                b_neg_q <= b_neg;
                opnd    <= i_op[2] ? b_mag : a_mag;
                acc     <= {32'd0, i_op[2] ? a_mag : b_mag};
                cnt     <= 6'd0;
                rd_q    <= i_rd_index;
                if (is_fast) begin
                    res_q  <= fast_val;
                    rd_out <= i_rd_index;
                end
            end else if (state == BUSY) begin
                acc <= step;
                cnt <= cnt + 6'd1;
                if (cnt == 6'd31) begin
                    res_q  <= final_val;
                    rd_out <= rd_q;
                end
            end
        end
    end

    assign o_result   = res_q;
    assign o_rd_index = rd_out;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - scoreboard testbench for ex_muldiv
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [2:0]  i_op = 3'd0;
    logic [31:0] i_rs1_data = 32'd0;
    logic [31:0] i_rs2_data = 32'd0;
    logic [4:0]  i_rd_index = 5'd0;
    logic        i_flush = 1'b0;
    logic        i_hold = 1'b0;
    logic        o_stall, o_done;
    logic [31:0] o_result;
    logic [4:0]  o_rd_index;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;
    exp_t sb_q[$];

    ex_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_op(i_op),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_rd_index(i_rd_index),
        .i_flush(i_flush), .i_hold(i_hold), .o_stall(o_stall), .o_done(o_done),
        .o_result(o_result), .o_rd_index(o_rd_index)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0]        p;
        logic signed [31:0] sq;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        p  = 64'd0;
        sq = 32'sd0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sq = $signed(a) / $signed(b);
                return sq;
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                sq = $signed(a) % $signed(b);
                return sq;
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2]) begin
            if (b == 32'd0) return 1;
            if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
`ifdef FAST_MUL_EN
        return 1;
`else
        return 33;
`endif
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issues one op at the current negedge, checks latency, stall count, result and single-cycle done
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res, input int lat_req);
        int   lat;
        int   stalls;
        int   stall_req;
        exp_t e;
        i_op = op; i_rs1_data = a; i_rs2_data = b; i_rd_index = rd; i_start = 1'b1;
        sb_q.push_back('{res: exp_res, rd: rd});
        stall_req = (lat_req == 1) ? 0 : 33;
        #1;
        stalls = o_stall ? 1 : 0;
        @(negedge clk);
        i_start = 1'b0;
        lat = 1;
        while (!o_done && lat < 60) begin
            if (o_stall) stalls++;
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat !== lat_req) begin
            n_fail++;
            $display("FAIL latency op=%0d got %0d want %0d", op, lat, lat_req);
        end
        n_cmp++;
        if (stalls !== stall_req) begin
            n_fail++;
            $display("FAIL stall_cycles op=%0d got %0d want %0d", op, stalls, stall_req);
        end
        n_cmp++;
        if (o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_in_done got %b want 0", o_stall);
        end
        if (sb_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard_empty got 0 entries want 1");
        end else begin
            e = sb_q.pop_front();
            n_cmp++;
            if (o_result !== e.res) begin
                n_fail++;
                $display("FAIL result op=%0d a=%h b=%h got %h want %h", op, a, b, o_result, e.res);
            end
            n_cmp++;
            if (o_rd_index !== e.rd) begin
                n_fail++;
                $display("FAIL rd_index got %0d want %0d", o_rd_index, e.rd);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_one_cycle got %b want 0", o_done);
        end
    endtask

    task automatic test_reset();
        i_start = 1'b1;
        #1;
        n_cmp++;
        if (o_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", o_stall); end
        n_cmp++;
        if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", o_done); end
        n_cmp++;
        if (o_result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", o_result); end
        n_cmp++;
        if (o_rd_index !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %0d want 0", o_rd_index); end
        @(negedge clk);
        i_start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_divide();
        run_op(3'd4, 32'd100, 32'd7, 5'd9, 32'd14, 33);
        run_op(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd10, 32'hFFFF_FFFE, 33);
        run_op(3'd7, 32'hFFFF_FFEC, 32'd3, 5'd11, 32'h0000_0002, 33);
        run_op(3'd5, 32'hFFFF_FFFF, 32'd16, 5'd12, 32'h0FFF_FFFF, 33);
    endtask

    task automatic test_fast_div();
        run_op(3'd5, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 1);
        run_op(3'd7, 32'd1234, 32'd0, 5'd16, 32'd1234, 1);
        run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 33);
    endtask

    task automatic test_multiply();
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd18, 32'h4000_0000, exp_lat(3'd1, 0, 0));
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19, 32'hFFFF_FFFF, exp_lat(3'd2, 0, 0));
        run_op(3'd0, 32'h0001_0000, 32'h0001_0000, 5'd20, 32'h0000_0000, exp_lat(3'd0, 0, 0));
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21, 32'hFFFF_FFFE, exp_lat(3'd3, 0, 0));
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 5'd22, 32'hFFFF_FFEB, exp_lat(3'd0, 0, 0));
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            run_op(op, a, b, 5'($urandom_range(1, 31)), ref_op(op, a, b), exp_lat(op, a, b));
        end
    endtask

    task automatic test_flush();
        logic [31:0] prev;
        i_op = 3'd4; i_rs1_data = 32'd1000; i_rs2_data = 32'd3; i_rd_index = 5'd5; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (8) @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        n_cmp++;
        if (o_done !== 1'b0 || o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_mid done=%b stall=%b want 0 0", o_done, o_stall);
        end
        run_op(3'd4, 32'd1000, 32'd3, 5'd6, 32'd333, 33);
        prev = o_result;
        i_op = 3'd5; i_rs1_data = 32'd77; i_rs2_data = 32'd5; i_rd_index = 5'd7; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (31) @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        n_cmp++;
        if (o_done !== 1'b0) begin n_fail++; $display("FAIL flush_last_done got %b want 0", o_done); end
        n_cmp++;
        if (o_result !== prev) begin n_fail++; $display("FAIL flush_last_result got %h want %h", o_result, prev); end
        @(negedge clk);
        n_cmp++;
        if (o_done !== 1'b0) begin n_fail++; $display("FAIL flush_late_done got %b want 0", o_done); end
    endtask

    task automatic test_hold();
        int   lat;
        exp_t e;
        logic [31:0] held;
        i_op = 3'd4; i_rs1_data = 32'hFFFF_FF9C; i_rs2_data = 32'd7; i_rd_index = 5'd25; i_start = 1'b1;
        sb_q.push_back('{res: 32'hFFFF_FFF2, rd: 5'd25});
        @(negedge clk);
        i_start = 1'b0;
        lat = 1;
        while (!o_done && lat < 60) begin @(negedge clk); lat++; end
        n_cmp++;
        if (lat !== 33) begin n_fail++; $display("FAIL hold_latency got %0d want 33", lat); end
        e = sb_q.pop_front();
        n_cmp++;
        if (o_result !== e.res || o_rd_index !== e.rd) begin
            n_fail++;
            $display("FAIL hold_result got %h/%0d want %h/%0d", o_result, o_rd_index, e.res, e.rd);
        end
        held = o_result;
        i_hold = 1'b1;
        i_start = 1'b1;
        i_rs2_data = 32'd0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 3) i_hold = 1'b0;
            n_cmp++;
            if (o_done !== 1'b1 || o_result !== held || o_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stable c=%0d done=%b result=%h stall=%b want 1 %h 0", c, o_done, o_result, o_stall, held);
            end
        end
        i_start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_done !== 1'b0 || o_result !== held) begin
            n_fail++;
            $display("FAIL hold_release done=%b result=%h want 0 %h", o_done, o_result, held);
        end
        @(negedge clk);
        n_cmp++;
        if (o_done !== 1'b0) begin n_fail++; $display("FAIL hold_retrigger done=%b want 0", o_done); end
    endtask

    task automatic test_reset_busy();
        i_op = 3'd5; i_rs1_data = 32'd999; i_rs2_data = 32'd4; i_rd_index = 5'd30; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (o_stall !== 1'b0 || o_done !== 1'b0 || o_result !== 32'd0 || o_rd_index !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_busy stall=%b done=%b result=%h rd=%0d want 0 0 0 0", o_stall, o_done, o_result, o_rd_index);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(3'd5, 32'd999, 32'd4, 5'd30, 32'd249, 33);
    endtask

    task automatic test_back_to_back();
        run_op(3'd7, 32'd999, 32'd4, 5'd1, 32'd3, 33);
        run_op(3'd4, 32'd7, 32'd0, 5'd2, 32'hFFFF_FFFF, 1);
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 5'd3, 32'hFFFF_FFFF, exp_lat(3'd1, 0, 0));
        n_cmp++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got %0d want 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_divide();
        test_fast_div();
        test_multiply();
        test_random();
        test_flush();
        test_hold();
        test_reset_busy();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
